// File: rtl/fsk_clkgen.sv
// FSK clock divider: produces a ~50% duty divided clock whose period switches
// between div0 and div1 according to sel, changing only at period boundaries.
module fsk_clkgen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] div0,
    input  logic [WIDTH-1:0] div1,
    output logic             clk_out,
    output logic             tick,
    output logic             sel_active
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] n_act, n_act_nxt;
    logic [WIDTH-1:0] n_raw, n_start, high_len;
    logic             clk_out_nxt, tick_nxt, sel_active_nxt;
    logic             start;

    // Divisors below 2 cannot form a period with both a high and a low phase.
    always_comb begin
        n_raw    = sel ? div1 : div0;
        n_start  = (n_raw < WIDTH'(2)) ? WIDTH'(2) : n_raw;
        high_len = n_act - (n_act >> 1);
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        n_act_nxt      = n_act;
        clk_out_nxt    = 1'b0;
        tick_nxt       = 1'b0;
        sel_active_nxt = sel_active;
        start          = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == n_act - WIDTH'(1)) begin
                    start = 1'b1;
                end else begin
                    cnt_nxt     = cnt + WIDTH'(1);
                    clk_out_nxt = (cnt + WIDTH'(1)) < high_len;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A period start re-samples sel and the divisors; nothing else does.
        if (start) begin
            cnt_nxt        = '0;
            n_act_nxt      = n_start;
            sel_active_nxt = sel;
            clk_out_nxt    = 1'b1;
            tick_nxt       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            n_act      <= WIDTH'(2);
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            sel_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            n_act      <= n_act_nxt;
            clk_out    <= clk_out_nxt;
            tick       <= tick_nxt;
            sel_active <= sel_active_nxt;
        end
    end

endmodule
